// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck CPU.
// Holds the eight opcode encodings (ASCII), the loop-controller error codes,
// the loop-controller FSM state encoding and a small opcode classifier.
package bf_pkg;

    localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'
    localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN    = 8'h2C;  // ','

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVF       = 2'd1;
    localparam logic [1:0] ERR_UNMATCHED = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESOLVE = 3'd1,
        ST_SCAN    = 3'd2,
        ST_REPORT  = 3'd3,
        ST_ERROR   = 3'd4
    } loop_state_t;

    // Bracket class of a program word: 2'b01 '[', 2'b10 ']', 2'b00 anything else.
    function automatic logic [1:0] bracket_class(input logic [7:0] word);
        logic [1:0] cls;
        case (word)
            OP_OPEN:  cls = 2'b01;
            OP_CLOSE: cls = 2'b10;
            default:  cls = 2'b00;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/bf_loop_ctrl_if.sv
// Bus between the loop controller and its neighbours.
// master: decoder/fetch/program-memory side; slave: the loop controller.
//   op_*        bracket op handshake and operands from the decoder
//   done/pc_next next-PC result for fetch
//   imem_*      shared program-memory read port (scan only)
//   stack_depth/err/err_code status
interface bf_loop_ctrl_if #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 16
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic               op_valid;
    logic               op_ready;
    logic               op_is_open;
    logic               op_is_close;
    logic [ADDR_W-1:0]  op_pc;
    logic               cell_zero;
    logic               done;
    logic [ADDR_W-1:0]  pc_next;
    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [DATA_W-1:0]  imem_data;
    logic [DEPTH_W-1:0] stack_depth;
    logic               err;
    logic [1:0]         err_code;

    modport master (
        output op_valid, op_is_open, op_is_close, op_pc, cell_zero, imem_data,
        input  op_ready, done, pc_next, imem_rd_en, imem_addr, stack_depth, err, err_code
    );

    modport slave (
        input  op_valid, op_is_open, op_is_close, op_pc, cell_zero, imem_data,
        output op_ready, done, pc_next, imem_rd_en, imem_addr, stack_depth, err, err_code
    );

endinterface

// File: rtl/bf_loop_stack.sv
// LIFO of open-bracket addresses, STACK_DEPTH entries of ADDR_W bits.
// Ports: clk, rst (sync, active-high), i_push/i_pop (never both in one cycle),
// i_din push data, o_top newest entry, o_depth entry count, o_full, o_empty.
// Push when full and pop when empty are ignored.
module bf_loop_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 16,
    localparam int PTR_W      = $clog2(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_din,
    output logic [ADDR_W-1:0] o_top,
    output logic [PTR_W:0]    o_depth,
    output logic              o_full,
    output logic              o_empty
);
    localparam logic [PTR_W:0]   DEPTH_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   DEPTH_MAX = (PTR_W+1)'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [PTR_W:0]    r_depth;
    logic [PTR_W-1:0]  w_top_idx;

    assign o_full    = (r_depth == DEPTH_MAX);
    assign o_empty   = (r_depth == {(PTR_W+1){1'b0}});
    assign w_top_idx = r_depth[PTR_W-1:0] - IDX_ONE;
    assign o_top     = r_mem[w_top_idx];
    assign o_depth   = r_depth;

    // Entry storage; written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_depth[PTR_W-1:0]] <= i_din;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= {(PTR_W+1){1'b0}};
        end else if (i_push && !o_full) begin
            r_depth <= r_depth + DEPTH_ONE;
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - DEPTH_ONE;
        end else begin
            r_depth <= r_depth;
        end
    end

endmodule

// File: rtl/bf_loop_ctrl.sv
// Loop-sequencing controller: resolves '[' / ']' ops and returns the next PC.
// Ports: clk, rst (sync, active-high), bus (bf_loop_ctrl_if.slave) carrying
// the op handshake, the done/pc_next result, the program-memory read port
// used for forward scans, and the stack_depth/err/err_code status.
module bf_loop_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    bf_loop_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    loop_state_t       r_state, w_next_state;
    logic              r_ready, r_done, r_err;
    logic [1:0]        r_err_code, w_err_code_d;
    logic              r_is_open, r_cell_zero;
    logic [ADDR_W-1:0] r_pc, r_pc_next, w_pc_next_d;
    logic [ADDR_W-1:0] r_scan_cnt, w_scan_cnt_d;
    logic              r_rd_en, w_rd_en_d;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_d;
    logic              r_eval_valid;      // imem_data holds the word at r_eval_addr
    logic [ADDR_W-1:0] r_eval_addr;
    logic              w_push, w_pop, w_full, w_empty, w_accept, w_illegal;
    logic              w_word_open, w_word_close;
    logic [ADDR_W-1:0] w_top;
    logic [1:0]        w_word_cls;

    bf_loop_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_pc),
        .o_top   (w_top),
        .o_depth (bus.stack_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_accept     = bus.op_valid && r_ready;
    assign w_illegal    = (bus.op_is_open == bus.op_is_close);
    assign w_word_cls   = bracket_class(8'(bus.imem_data));
    assign w_word_open  = w_word_cls[0];
    assign w_word_close = w_word_cls[1];

    assign bus.op_ready   = r_ready;
    assign bus.done       = r_done;
    assign bus.pc_next    = r_pc_next;
    assign bus.imem_rd_en = r_rd_en;
    assign bus.imem_addr  = r_rd_addr;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;

    // Next-state, stack commands, result PC and scan read stream.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_pc_next_d  = r_pc_next;
        w_err_code_d = r_err_code;
        w_rd_en_d    = 1'b0;
        w_rd_addr_d  = r_rd_addr;
        w_scan_cnt_d = r_scan_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_illegal) begin
                    w_next_state = ST_ERROR;
                    w_err_code_d = ERR_ILLEGAL;
                end else if (w_accept) begin
                    w_next_state = ST_RESOLVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RESOLVE: begin
                if (r_is_open && !r_cell_zero) begin
                    if (w_full) begin
                        w_next_state = ST_ERROR;
                        w_err_code_d = ERR_OVF;
                    end else begin
                        w_push       = 1'b1;
                        w_pc_next_d  = r_pc + ADDR_ONE;
                        w_next_state = ST_REPORT;
                    end
                end else if (r_is_open) begin
                    // A '[' in the last word has nothing left to scan.
                    if (r_pc == ADDR_MAX) begin
                        w_next_state = ST_ERROR;
                        w_err_code_d = ERR_UNMATCHED;
                    end else begin
                        w_next_state = ST_SCAN;
                        w_scan_cnt_d = ADDR_ONE;
                        w_rd_en_d    = 1'b1;
                        w_rd_addr_d  = r_pc + ADDR_ONE;
                    end
                end else if (w_empty) begin
                    w_next_state = ST_ERROR;
                    w_err_code_d = ERR_UNMATCHED;
                end else if (!r_cell_zero) begin
                    // Jump to the body start; the '[' stays stacked.
                    w_pc_next_d  = w_top + ADDR_ONE;
                    w_next_state = ST_REPORT;
                end else begin
                    w_pop        = 1'b1;
                    w_pc_next_d  = r_pc + ADDR_ONE;
                    w_next_state = ST_REPORT;
                end
            end
            ST_SCAN: begin
                // Keep one read in flight; stop at the top of memory rather than wrap.
                if (r_rd_en && (r_rd_addr != ADDR_MAX)) begin
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = r_rd_addr + ADDR_ONE;
                end else begin
                    w_rd_en_d   = 1'b0;
                end
                if (r_eval_valid) begin
                    if (w_word_open) begin
                        w_scan_cnt_d = r_scan_cnt + ADDR_ONE;
                    end else if (w_word_close) begin
                        w_scan_cnt_d = r_scan_cnt - ADDR_ONE;
                    end else begin
                        w_scan_cnt_d = r_scan_cnt;
                    end
                    if (w_word_close && (r_scan_cnt == ADDR_ONE)) begin
                        // Match found; the read issued this cycle is discarded.
                        w_rd_en_d    = 1'b0;
                        w_pc_next_d  = r_eval_addr + ADDR_ONE;
                        w_next_state = ST_REPORT;
                    end else if (r_eval_addr == ADDR_MAX) begin
                        w_rd_en_d    = 1'b0;
                        w_next_state = ST_ERROR;
                        w_err_code_d = ERR_UNMATCHED;
                    end else begin
                        w_next_state = ST_SCAN;
                    end
                end else begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_REPORT: w_next_state = ST_IDLE;
            ST_ERROR:  w_next_state = ST_ERROR;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_pc_next    <= {ADDR_W{1'b0}};
            r_rd_en      <= 1'b0;
            r_rd_addr    <= {ADDR_W{1'b0}};
            r_eval_valid <= 1'b0;
            r_eval_addr  <= {ADDR_W{1'b0}};
            r_scan_cnt   <= {ADDR_W{1'b0}};
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_next_state;
            r_ready      <= (w_next_state == ST_IDLE);
            r_done       <= (w_next_state == ST_REPORT);
            r_pc_next    <= w_pc_next_d;
            r_rd_en      <= w_rd_en_d;
            r_rd_addr    <= w_rd_addr_d;
            r_eval_valid <= r_rd_en;
            r_eval_addr  <= r_rd_addr;
            r_scan_cnt   <= w_scan_cnt_d;
            r_err        <= r_err | (w_next_state == ST_ERROR);
            r_err_code   <= w_err_code_d;
        end
    end

    // Operand capture at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= {ADDR_W{1'b0}};
            r_is_open   <= 1'b0;
            r_cell_zero <= 1'b0;
        end else if (w_accept) begin
            r_pc        <= bus.op_pc;
            r_is_open   <= bus.op_is_open;
            r_cell_zero <= bus.cell_zero;
        end else begin
            r_pc        <= r_pc;
            r_is_open   <= r_is_open;
            r_cell_zero <= r_cell_zero;
        end
    end

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Self-checking bench for bf_loop_ctrl: directed cases plus a randomized
// op stream, compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_bf_loop_ctrl;
    import bf_pkg::*;

    localparam int ADDR_W = 12, DATA_W = 8, STACK_DEPTH = 16;
    localparam int AMAX = 4095;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bf_loop_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) bus ();
    bf_loop_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [0:AMAX];
    int cyc = 0;
    int n_checks = 0, n_fail = 0;

    // Expectation of the most recent op.
    int stk[$];
    bit exp_active = 0, exp_is_err = 0, exp_scan = 0;
    int exp_k = 0, exp_end = 0, exp_err_cyc = 0, exp_code = 0, exp_pc = 0;
    int exp_depth_old = 0, exp_depth_new = 0, scan_lo = 0, scan_hi = 0;
    int done_seen = 0, last_done_pc = -1, last_done_cyc = 0, rd_cnt = 0;
    bit prev_rd = 0;
    int prev_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Program memory: data valid one cycle after the read request.
    always @(posedge clk) if (bus.imem_rd_en) bus.imem_data <= mem[bus.imem_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] filler();
        case ($urandom_range(0, 5))
            0: return OP_INC;
            1: return OP_DEC;
            2: return OP_RIGHT;
            3: return OP_LEFT;
            4: return OP_OUT;
            default: return OP_IN;
        endcase
    endfunction

    // Per-cycle compare against the expectation of the current op.
    bit c_busy, c_done, c_err;
    always @(negedge clk) begin
        if (!rst) begin
            c_busy = exp_active && cyc >= exp_k && (exp_is_err || cyc <= exp_end);
            c_done = exp_active && !exp_is_err && cyc == exp_end;
            c_err  = exp_active && exp_is_err && cyc >= exp_err_cyc;
            chk("op_ready", bus.op_ready, !c_busy);
            chk("done", bus.done, c_done);
            chk("err", bus.err, c_err);
            chk("err_code", bus.err_code, c_err ? exp_code : 0);
            if (c_done) chk("pc_next", bus.pc_next, exp_pc);
            chk("stack_depth", bus.stack_depth,
                (exp_active && cyc >= exp_k + 1) ? exp_depth_new : exp_depth_old);
            if (bus.imem_rd_en) begin
                rd_cnt++;
                chk("imem_window", exp_active && exp_scan &&
                    int'(bus.imem_addr) > scan_lo && int'(bus.imem_addr) <= scan_hi, 1);
                if (prev_rd) chk("imem_seq", bus.imem_addr, prev_addr + 1);
            end
            prev_rd   = bus.imem_rd_en;
            prev_addr = int'(bus.imem_addr);
            if (bus.done) begin
                done_seen++;
                last_done_pc  = int'(bus.pc_next);
                last_done_cyc = cyc;
            end
        end else begin
            prev_rd = 0;
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1; the op is accepted on the next edge.
    task automatic issue(input bit op_o, input bit op_c, input int pc, input bit cz, input bit wait_end);
        int k, cnt, match;
        k = cyc + 1;
        exp_k = k; exp_is_err = 0; exp_code = 0; exp_scan = 0;
        exp_depth_old = stk.size();
        if (op_o == op_c) begin
            exp_is_err = 1; exp_code = 3; exp_err_cyc = k;
        end else if (op_o && !cz) begin
            if (stk.size() == STACK_DEPTH) begin
                exp_is_err = 1; exp_code = 1; exp_err_cyc = k + 1;
            end else begin
                stk.push_back(pc); exp_pc = (pc + 1) % 4096; exp_end = k + 1;
            end
        end else if (op_o) begin
            cnt = 1; match = -1;
            for (int a = pc + 1; a <= AMAX && match < 0; a++) begin
                if (mem[a] == OP_OPEN) cnt++;
                else if (mem[a] == OP_CLOSE) begin
                    cnt--;
                    if (cnt == 0) match = a;
                end
            end
            if (pc == AMAX) begin
                exp_is_err = 1; exp_code = 2; exp_err_cyc = k + 1;
            end else if (match >= 0) begin
                // One word evaluated per cycle after the first read is issued.
                exp_scan = 1; scan_lo = pc; scan_hi = match + 1;
                exp_pc = (match + 1) % 4096; exp_end = k + 2 + (match - pc);
            end else begin
                exp_scan = 1; scan_lo = pc; scan_hi = AMAX;
                exp_is_err = 1; exp_code = 2; exp_err_cyc = k + 2 + (AMAX - pc);
            end
        end else begin
            if (stk.size() == 0) begin
                exp_is_err = 1; exp_code = 2; exp_err_cyc = k + 1;
            end else if (!cz) begin
                exp_pc = (stk[$] + 1) % 4096; exp_end = k + 1;
            end else begin
                void'(stk.pop_back()); exp_pc = (pc + 1) % 4096; exp_end = k + 1;
            end
        end
        exp_depth_new = stk.size();
        exp_active = 1;
        bus.op_valid = 1'b1; bus.op_is_open = op_o; bus.op_is_close = op_c;
        bus.op_pc = ADDR_W'(pc); bus.cell_zero = cz;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.op_pc = ADDR_W'($urandom);
        if (wait_end) begin
            if (exp_is_err) wait_until(exp_err_cyc + 2);
            else wait_until(exp_end + 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.op_valid = 1'b0;
        stk.delete();
        exp_active = 0; exp_scan = 0; exp_depth_old = 0; exp_depth_new = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    int d0, o, a, p, len, r, k0;
    initial begin
        bus.op_valid = 1'b0; bus.op_is_open = 1'b0; bus.op_is_close = 1'b0;
        bus.op_pc = '0; bus.cell_zero = 1'b0; bus.imem_data = '0;
        for (int i = 0; i <= AMAX; i++) mem[i] = filler();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_pc_next", bus.pc_next, 0);
        chk("rst_rd_en", bus.imem_rd_en, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_depth", bus.stack_depth, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_code", bus.err_code, 0);
        @(posedge clk); #1;

        // '[' taken, then ']' looping back, then ']' falling through.
        issue(1, 0, 'h010, 0, 1);
        chk("t1_pc", last_done_pc, 'h011);
        chk("t1_latency", last_done_cyc + 1 - exp_k, 2);
        chk("t1_depth", bus.stack_depth, 1);
        issue(0, 1, 'h020, 0, 1);
        chk("t2_pc", last_done_pc, 'h011);
        chk("t2_depth", bus.stack_depth, 1);
        issue(0, 1, 'h020, 1, 1);
        chk("t3_pc", last_done_pc, 'h021);
        chk("t3_depth", bus.stack_depth, 0);
        chk("t3_err", bus.err, 0);

        // Forward scan over "[+[-]>]".
        mem['h100] = OP_OPEN; mem['h101] = OP_INC; mem['h102] = OP_OPEN; mem['h103] = OP_DEC;
        mem['h104] = OP_CLOSE; mem['h105] = OP_RIGHT; mem['h106] = OP_CLOSE;
        rd_cnt = 0;
        issue(1, 0, 'h100, 1, 1);
        chk("scan_pc", last_done_pc, 'h107);
        chk("scan_reads_ok", rd_cnt >= 6 && rd_cnt <= 7, 1);
        chk("scan_depth", bus.stack_depth, 0);

        // ']' in the last word wraps pc_next to 0.
        issue(1, 0, 'h005, 0, 1);
        issue(0, 1, AMAX, 1, 1);
        chk("wrap_pc", last_done_pc, 0);

        // Overflow on the 17th nested '['.
        for (int i = 0; i < 16; i++) begin
            issue(1, 0, 'h200 + i, 0, 1);
            chk("nest_pc", last_done_pc, 'h201 + i);
        end
        chk("nest_depth", bus.stack_depth, 16);
        issue(1, 0, 'h210, 0, 1);
        repeat (5) begin @(posedge clk); #1; end
        chk("ovf_code", bus.err_code, 1);
        chk("ovf_err", bus.err, 1);
        chk("ovf_ready", bus.op_ready, 0);
        do_reset();

        // ']' on an empty stack.
        issue(0, 1, 'h040, 1, 1);
        chk("empty_code", bus.err_code, 2);
        do_reset();

        // Scan runs off the top of memory.
        for (int i = 'hFF1; i <= AMAX; i++) mem[i] = filler();
        rd_cnt = 0;
        issue(1, 0, 'hFF0, 1, 1);
        chk("edge_code", bus.err_code, 2);
        chk("edge_reads", rd_cnt, 15);
        do_reset();

        // Illegal flag combinations.
        issue(1, 1, 'h050, 0, 1);
        chk("ill_code_hh", bus.err_code, 3);
        do_reset();
        issue(0, 0, 'h050, 1, 1);
        chk("ill_code_ll", bus.err_code, 3);
        do_reset();

        // Reset in the middle of a long scan.
        mem['h300] = OP_OPEN;
        for (int i = 'h301; i < 'h340; i++) mem[i] = filler();
        mem['h340] = OP_CLOSE;
        issue(1, 0, 'h300, 1, 0);
        wait_until(exp_k + 6);
        d0 = done_seen;
        do_reset();
        @(negedge clk);
        chk("mid_ready", bus.op_ready, 1);
        chk("mid_depth", bus.stack_depth, 0);
        chk("mid_err", bus.err, 0);
        repeat (80) @(posedge clk);
        #1;
        chk("mid_no_done", done_seen, d0);

        // Randomized op stream.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                o = $urandom_range(0, 1);
                issue(o[0], o[0], $urandom_range(0, AMAX), 1'($urandom), 1);
            end else if (r < 40) begin
                issue(1, 0, $urandom_range(0, AMAX), 0, 1);
            end else if (r < 52) begin
                p = $urandom_range('h400, 'hE00);
                mem[p] = OP_OPEN; o = 0; a = p + 1; len = $urandom_range(0, 20);
                for (int i = 0; i < len; i++) begin
                    k0 = $urandom_range(0, 3);
                    if (k0 == 0) begin mem[a] = OP_OPEN; o++; end
                    else if (k0 == 1 && o > 0) begin mem[a] = OP_CLOSE; o--; end
                    else mem[a] = filler();
                    a++;
                end
                while (o > 0) begin mem[a] = OP_CLOSE; o--; a++; end
                mem[a] = OP_CLOSE;
                issue(1, 0, p, 1, 1);
            end else if (r < 55 || stk.size() > 0) begin
                issue(0, 1, $urandom_range(0, AMAX), 1'($urandom), 1);
            end else begin
                issue(1, 0, $urandom_range(0, AMAX), 0, 1);
            end
            if (exp_is_err) do_reset();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
